// File: rtl/epd_pkg.sv
// Shared types and constants for the parametrised Ethernet packet detector.
package epd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DST,
        ST_SRC,
        ST_TL,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_ADDR    = 48'hFFFF_FFFF_FFFF;
    localparam int          HDR_LEN       = 14;
    localparam int          FCS_LEN       = 4;
    localparam int          MIN_PAYLOAD   = 46;
    localparam logic [15:0] TYPE_MIN      = 16'h0600;
    localparam logic [15:0] LEN_MAX       = 16'd1500;
    localparam logic [10:0] BYTE_CNT_MAX  = 11'h7FF;

    // Short payloads are padded on the wire, so the frame length uses max(L, 46).
    function automatic logic [10:0] expected_len(input logic [15:0] len_field);
        logic [15:0] payload;
        payload = (len_field < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) : len_field;
        return 11'(payload + 16'(HDR_LEN + FCS_LEN));
    endfunction

endpackage

// File: rtl/epd_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module epd_sat_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/epd_param.sv
// Parametrised Ethernet packet detector: validates preamble, DST filter,
// type/length and frame size of a byte-wide MII stream, counting good/dropped frames.
module epd_param
    import epd_pkg::*;
#(
    parameter int          CNT_W     = 4,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518,
    parameter bit          FILTER_EN = 1'b0,
    parameter logic [47:0] MY_ADDR   = 48'h010203040506,
    parameter bit          LEN_CHECK = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             control,
    output logic             preamble_valid,
    output logic             dst_addr_valid,
    output logic             src_addr_valid,
    output logic             type_length_valid,
    output logic             packet_size_valid,
    output logic             frame_done,
    output logic [CNT_W-1:0] valid_packet_counter,
    output logic [CNT_W-1:0] drop_counter
);

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [47:0] addr_q, addr_d;
    logic [15:0] tl_q, tl_d;
    logic        is_len_q, is_len_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        pre_v_q, pre_v_d;
    logic        dst_v_q, dst_v_d;
    logic        src_v_q, src_v_d;
    logic        tl_v_q, tl_v_d;
    logic        psv_q, psv_d;
    logic        fd_q, fd_d;
    logic        count_drop_q, count_drop_d;
    logic        good_inc, drop_inc;

    logic [10:0] byte_cnt_inc;
    logic [47:0] dst_full;
    logic [15:0] tl_full;
    logic        addr_ok;
    logic        size_ok;

    assign byte_cnt_inc = (byte_cnt_q == BYTE_CNT_MAX) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign dst_full     = {addr_q[39:0], data};
    assign tl_full      = {tl_q[7:0], data};
    assign addr_ok      = !FILTER_EN || (dst_full == MY_ADDR) || (dst_full == BCAST_ADDR);
    assign size_ok      = (byte_cnt_q >= MIN_LEN_W) && (byte_cnt_q <= MAX_LEN_W) &&
                          !(LEN_CHECK && is_len_q && (byte_cnt_q != expected_len(tl_q)));

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        tl_d         = tl_q;
        is_len_d     = is_len_q;
        byte_cnt_d   = byte_cnt_q;
        pre_v_d      = pre_v_q;
        dst_v_d      = dst_v_q;
        src_v_d      = src_v_q;
        tl_v_d       = tl_v_q;
        count_drop_d = count_drop_q;
        psv_d        = 1'b0;
        fd_d         = 1'b0;
        good_inc     = 1'b0;
        drop_inc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Field flags of the previous frame survive exactly one cycle here.
                pre_v_d  = 1'b0;
                dst_v_d  = 1'b0;
                src_v_d  = 1'b0;
                tl_v_d   = 1'b0;
                is_len_d = 1'b0;
                if (control) begin
                    if (data == PREAMBLE_BYTE) begin
                        state_d   = ST_PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d      = ST_DROP;
                        count_drop_d = 1'b0;
                    end
                end
            end
            ST_PRE: begin
                if (!control) begin
                    state_d  = ST_IDLE;
                    drop_inc = 1'b1;
                    fd_d     = 1'b1;
                end else if (data == PREAMBLE_BYTE) begin
                    if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
                end else if ((data == SFD_BYTE) && (pre_cnt_q == 4'd7)) begin
                    state_d    = ST_DST;
                    pre_v_d    = 1'b1;
                    idx_d      = 3'd0;
                    byte_cnt_d = 11'd0;
                end else begin
                    state_d      = ST_DROP;
                    count_drop_d = 1'b1;
                end
            end
            ST_DST, ST_SRC, ST_TL: begin
                if (!control) begin
                    state_d  = ST_IDLE;
                    drop_inc = 1'b1;
                    fd_d     = 1'b1;
                end else begin
                    byte_cnt_d = byte_cnt_inc;
                    idx_d      = idx_q + 3'd1;
                    if (state_q == ST_DST) begin
                        addr_d = dst_full;
                        if (idx_q == 3'd5) begin
                            idx_d = 3'd0;
                            if (addr_ok) begin
                                state_d = ST_SRC;
                                dst_v_d = 1'b1;
                            end else begin
                                state_d      = ST_DROP;
                                count_drop_d = 1'b1;
                            end
                        end
                    end else if (state_q == ST_SRC) begin
                        if (idx_q == 3'd5) begin
                            idx_d   = 3'd0;
                            state_d = ST_TL;
                            src_v_d = 1'b1;
                        end
                    end else begin
                        tl_d = tl_full;
                        if (idx_q == 3'd1) begin
                            if (tl_full >= TYPE_MIN) begin
                                state_d  = ST_DATA;
                                tl_v_d   = 1'b1;
                                is_len_d = 1'b0;
                            end else if (tl_full <= LEN_MAX) begin
                                state_d  = ST_DATA;
                                tl_v_d   = 1'b1;
                                is_len_d = 1'b1;
                            end else begin
                                state_d      = ST_DROP;
                                count_drop_d = 1'b1;
                            end
                        end
                    end
                    if (state_d == ST_DROP) begin
                        pre_v_d = 1'b0;
                        dst_v_d = 1'b0;
                        src_v_d = 1'b0;
                        tl_v_d  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (control) begin
                    byte_cnt_d = byte_cnt_inc;
                end else begin
                    state_d  = ST_IDLE;
                    fd_d     = 1'b1;
                    psv_d    = size_ok;
                    good_inc = size_ok;
                    drop_inc = !size_ok;
                end
            end
            ST_DROP: begin
                pre_v_d = 1'b0;
                dst_v_d = 1'b0;
                src_v_d = 1'b0;
                tl_v_d  = 1'b0;
                if (!control) begin
                    state_d  = ST_IDLE;
                    drop_inc = count_drop_q;
                    fd_d     = count_drop_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DROP && state_q == ST_PRE) begin
            pre_v_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
            tl_q         <= '0;
            is_len_q     <= 1'b0;
            byte_cnt_q   <= '0;
            pre_v_q      <= 1'b0;
            dst_v_q      <= 1'b0;
            src_v_q      <= 1'b0;
            tl_v_q       <= 1'b0;
            psv_q        <= 1'b0;
            fd_q         <= 1'b0;
            count_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tl_q         <= tl_d;
            is_len_q     <= is_len_d;
            byte_cnt_q   <= byte_cnt_d;
            pre_v_q      <= pre_v_d;
            dst_v_q      <= dst_v_d;
            src_v_q      <= src_v_d;
            tl_v_q       <= tl_v_d;
            psv_q        <= psv_d;
            fd_q         <= fd_d;
            count_drop_q <= count_drop_d;
        end
    end

    epd_sat_counter #(.W(CNT_W)) u_good_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (good_inc),
        .count (valid_packet_counter)
    );

    epd_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_counter)
    );

    assign preamble_valid    = pre_v_q;
    assign dst_addr_valid    = dst_v_q;
    assign src_addr_valid    = src_v_q;
    assign type_length_valid = tl_v_q;
    assign packet_size_valid = psv_q;
    assign frame_done        = fd_q;

endmodule

// File: tb/tb_epd_param.sv
// Directed self-checking bench for epd_param: three instances (default,
// address filter on, 2-bit counters) share one stimulus bus selected by 'sel'.
module tb_epd_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       control = 1'b0;
    int         sel = 0;

    int checks = 0;
    int errors = 0;

    int         fd_cnt = 0;
    int         psv_cnt = 0;
    logic       pv_seen = 1'b0;
    logic [3:0] last_flags = 4'h0;

    always #5 clock = ~clock;

    logic ctrl_a, ctrl_b, ctrl_c;
    assign ctrl_a = control && (sel == 0);
    assign ctrl_b = control && (sel == 1);
    assign ctrl_c = control && (sel == 2);

    logic       pv_a, dv_a, sv_a, tv_a, psv_a, fd_a;
    logic       pv_b, dv_b, sv_b, tv_b, psv_b, fd_b;
    logic       pv_c, dv_c, sv_c, tv_c, psv_c, fd_c;
    logic [3:0] good_a, drop_a, good_b, drop_b;
    logic [1:0] good_c, drop_c;

    epd_param u_dut_a (
        .clock(clock), .reset(reset), .data(data), .control(ctrl_a),
        .preamble_valid(pv_a), .dst_addr_valid(dv_a), .src_addr_valid(sv_a),
        .type_length_valid(tv_a), .packet_size_valid(psv_a), .frame_done(fd_a),
        .valid_packet_counter(good_a), .drop_counter(drop_a)
    );

    epd_param #(.FILTER_EN(1'b1), .MY_ADDR(48'h010203040506)) u_dut_b (
        .clock(clock), .reset(reset), .data(data), .control(ctrl_b),
        .preamble_valid(pv_b), .dst_addr_valid(dv_b), .src_addr_valid(sv_b),
        .type_length_valid(tv_b), .packet_size_valid(psv_b), .frame_done(fd_b),
        .valid_packet_counter(good_b), .drop_counter(drop_b)
    );

    epd_param #(.CNT_W(2)) u_dut_c (
        .clock(clock), .reset(reset), .data(data), .control(ctrl_c),
        .preamble_valid(pv_c), .dst_addr_valid(dv_c), .src_addr_valid(sv_c),
        .type_length_valid(tv_c), .packet_size_valid(psv_c), .frame_done(fd_c),
        .valid_packet_counter(good_c), .drop_counter(drop_c)
    );

    logic [3:0] sel_flags, sel_good, sel_drop;
    logic       sel_psv, sel_fd;

    always_comb begin
        sel_flags = {pv_a, dv_a, sv_a, tv_a};
        sel_psv   = psv_a;
        sel_fd    = fd_a;
        sel_good  = good_a;
        sel_drop  = drop_a;
        if (sel == 1) begin
            sel_flags = {pv_b, dv_b, sv_b, tv_b};
            sel_psv   = psv_b;
            sel_fd    = fd_b;
            sel_good  = good_b;
            sel_drop  = drop_b;
        end else if (sel == 2) begin
            sel_flags = {pv_c, dv_c, sv_c, tv_c};
            sel_psv   = psv_c;
            sel_fd    = fd_c;
            sel_good  = {2'b00, good_c};
            sel_drop  = {2'b00, drop_c};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One byte time: drive, clock, then record what the selected instance reports.
    task automatic step(input logic c, input logic [7:0] d);
        control = c;
        data    = d;
        @(posedge clock);
        #1;
        if (sel_flags[3]) pv_seen = 1'b1;
        if (sel_psv) psv_cnt++;
        if (sel_fd) begin
            fd_cnt++;
            last_flags = sel_flags;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        control = 1'b0;
        reset   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b1;
        idle(1);
        fd_cnt     = 0;
        psv_cnt    = 0;
        pv_seen    = 1'b0;
        last_flags = 4'h0;
    endtask

    // len counts DST..FCS; cut>0 stops after that many post-SFD bytes.
    task automatic send_frame(input int pre_n, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] tl, input int len, input int cut, input bit ifg);
        logic [7:0] b;
        for (int i = 0; i < pre_n; i++) step(1'b1, 8'h55);
        step(1'b1, 8'hD5);
        for (int i = 0; i < len; i++) begin
            if (cut != 0 && i == cut) break;
            if (i < 6)            b = dst[47-8*i -: 8];
            else if (i < 12)      b = src[47-8*(i-6) -: 8];
            else if (i == 12)     b = tl[15:8];
            else if (i == 13)     b = tl[7:0];
            else if (i == len-1)  b = 8'h56;
            else                  b = 8'h55;
            step(1'b1, b);
        end
        if (ifg) idle(1);
    endtask

    localparam logic [47:0] ADDR_ME  = 48'h010203040506;
    localparam logic [47:0] ADDR_SRC = 48'hFFFEFDFCFBFA;

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("reset_flags", {28'd0, sel_flags}, 32'd0);
        check("reset_psv_fd", {30'd0, sel_psv, sel_fd}, 32'd0);
        check("reset_good", {28'd0, good_a}, 32'd0);
        check("reset_drop", {28'd0, drop_a}, 32'd0);
        reset = 1'b1;
        idle(1);

        // 1: three back-to-back good frames
        sel = 0;
        for (int f = 0; f < 3; f++) begin
            send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
            check("t1_flags_at_done", {28'd0, last_flags}, 32'hF);
        end
        idle(4);
        check("t1_good", {28'd0, sel_good}, 32'd3);
        check("t1_drop", {28'd0, sel_drop}, 32'd0);
        check("t1_frame_done", fd_cnt, 32'd3);
        check("t1_psv_cycles", psv_cnt, 32'd3);
        check("t1_flags_cleared", {28'd0, sel_flags}, 32'd0);

        // 2: short preamble
        apply_reset();
        send_frame(6, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t2_pv_never", {31'd0, pv_seen}, 32'd0);
        check("t2_drop", {28'd0, sel_drop}, 32'd1);
        check("t2_done", fd_cnt, 32'd1);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t2_good_after", {28'd0, sel_good}, 32'd1);

        // 3: address filter
        apply_reset();
        sel = 1;
        send_frame(7, 48'h010203040507, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t3_wrong_dst_drop", {28'd0, sel_drop}, 32'd1);
        send_frame(7, 48'hFFFFFFFFFFFF, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t3_bcast_good", {28'd0, sel_good}, 32'd1);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t3_good", {28'd0, sel_good}, 32'd2);
        check("t3_drop", {28'd0, sel_drop}, 32'd1);

        // 4: size and length checks
        apply_reset();
        sel = 0;
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 60, 0, 1'b1);
        check("t4_runt_drop", {28'd0, sel_drop}, 32'd1);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 1519, 0, 1'b1);
        check("t4_giant_drop", {28'd0, sel_drop}, 32'd2);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'd46, 64, 0, 1'b1);
        check("t4_len46_good", {28'd0, sel_good}, 32'd1);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'd100, 64, 0, 1'b1);
        check("t4_len100_drop", {28'd0, sel_drop}, 32'd3);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h05F0, 64, 0, 1'b1);
        check("t4_bad_tl_drop", {28'd0, sel_drop}, 32'd4);
        check("t4_bad_tl_flags", {28'd0, last_flags}, 32'd0);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 1518, 0, 1'b1);
        check("t4_max_good", {28'd0, sel_good}, 32'd2);
        check("t4_psv_cycles", psv_cnt, 32'd2);

        // 5: abort in SRC, then async reset mid-DATA
        apply_reset();
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 9, 1'b1);
        check("t5_abort_done", fd_cnt, 32'd1);
        check("t5_abort_drop", {28'd0, sel_drop}, 32'd1);
        check("t5_abort_flags_at_done", {28'd0, last_flags}, 32'hC);
        idle(1);
        check("t5_flags_cleared", {28'd0, sel_flags}, 32'd0);
        send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 20, 1'b0);
        check("t5_in_data_flags", {28'd0, sel_flags}, 32'hF);
        reset = 1'b0;
        #1;
        check("t5_async_flags", {28'd0, sel_flags}, 32'd0);
        check("t5_async_psv_fd", {30'd0, sel_psv, sel_fd}, 32'd0);
        check("t5_async_drop", {28'd0, sel_drop}, 32'd0);
        check("t5_async_good", {28'd0, sel_good}, 32'd0);
        control = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 6: 2-bit counter saturation
        apply_reset();
        sel = 2;
        for (int f = 0; f < 3; f++) send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t6_good_at_max", {28'd0, sel_good}, 32'd3);
        for (int f = 0; f < 2; f++) send_frame(7, ADDR_ME, ADDR_SRC, 16'h0800, 64, 0, 1'b1);
        check("t6_good_saturated", {28'd0, sel_good}, 32'd3);
        check("t6_drop", {28'd0, sel_drop}, 32'd0);
        check("t6_frame_done", fd_cnt, 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
